arc_mem_ctrl: RTL and testbench

Memory access controller between the ARC datapath control unit and main_memory. It converts a single-outstanding request/acknowledge transaction from the datapath into main_memory's rd/wr strobes. It also absorbs main_memory's registered-read latency plus a configurable number of wait states. It returns read data in a holding register and rejects misaligned word accesses before they reach memory.

---
 rtl/arc_mem_pkg.sv | 12 +
 rtl/arc_mem_ctrl.sv | 83 ++++++++
 tb/tb_arc_mem_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/arc_mem_pkg.sv
// arc_mem_pkg: shared FSM state encoding and alignment constants for the ARC memory controller
package arc_mem_pkg;
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WR   = 3'd2,
      CAP  = 3'd3,
      ACK  = 3'd4
   } state_t;
   localparam logic [1:0] ALIGN_MASK     = 2'b11;
   localparam int         ARC_WORD_BYTES = 4;
endpackage

// File: rtl/arc_mem_ctrl.sv
// arc_mem_ctrl: single-outstanding request/ack bridge from the ARC datapath to main_memory rd/wr strobes
// Ports: cpu_req/cpu_we/cpu_addr/cpu_wdata sampled in IDLE; cpu_ack pulses one cycle with cpu_err
// (misaligned) and cpu_rdata (held read data); busy outside IDLE; mem_* drive main_memory from
// the latched request, mem_data_out is main_memory's registered read data.
module arc_mem_ctrl
   import arc_mem_pkg::*;
#(
   parameter int WAIT_STATES = 1,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_data_out
);
   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [3:0]        r_cnt;
   logic              r_err;
   logic              w_accept;
   logic              w_misaligned;
   assign w_accept     = (r_state == IDLE) && cpu_req;
   assign w_misaligned = |(cpu_addr[1:0] & ALIGN_MASK);
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = IDLE;
      case (r_state)
         IDLE:    w_next = !cpu_req ? IDLE : w_misaligned ? ACK : cpu_we ? WR : RD;
         RD:      w_next = (r_cnt == 4'd1) ? CAP : RD;
         WR:      w_next = ACK;
         CAP:     w_next = ACK;
         default: w_next = IDLE;
      endcase
   end
   always_comb begin
      mem_rd  = (r_state == RD);
      mem_wr  = (r_state == WR);
      cpu_ack = (r_state == ACK);
      cpu_err = (r_state == ACK) && r_err;
      busy    = (r_state != IDLE);
   end
   // The counter is reloaded on every accepted request; only the RD state consumes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_err   <= w_misaligned;
            r_cnt   <= 4'(WAIT_STATES);
         end else if (r_state == RD) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (r_state == CAP) r_rdata <= mem_data_out;
      end
   end
   assign cpu_rdata   = r_rdata;
   assign mem_address = r_addr;
   assign mem_data_in = r_wdata;
endmodule

// File: tb/tb_arc_mem_ctrl.sv
// tb_arc_mem_ctrl: scoreboard bench for arc_mem_ctrl with a behavioural main_memory and reference model
module tb_arc_mem_ctrl;
   localparam int WS = 3;
   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ack;
   logic        cpu_err;
   logic        busy;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_data_out;
   arc_mem_ctrl #(.WAIT_STATES(WS), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
      .busy(busy), .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_data_out(mem_data_out)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          ack_cyc;
      int          rd_n;
      int          wr_n;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;
   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mem[32];
   logic [31:0] ref_mem[32];
   logic [31:0] ref_rdata;
   function automatic logic [31:0] img(int i);
      return i == 0 ? 32'hC2002818 : i == 4 ? 32'h81C3E810 : i == 5 ? 32'h00000070 :
             i == 6 ? 32'h00000003 : 32'h1000_0000 + 32'(i * 273);
   endfunction
   function automatic int widx(logic [31:0] a);
      return int'((a - 32'd2048) >> 2) & 31;
   endfunction
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // main_memory stand-in: registered read, write on the edge, image reload on reset
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= img(i);
         mem_data_out <= '0;
      end else begin
         if (mem_wr) mem[widx(mem_address)] <= mem_data_in;
         if (mem_rd) mem_data_out <= mem[widx(mem_address)];
      end
   end
   int          rd_seen = 0;
   int          wr_seen = 0;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   always @(negedge clk) begin
      if (rst) begin
         rd_seen = 0;
         wr_seen = 0;
      end else begin
         if (mem_rd) begin
            rd_seen++;
            if (q.size() > 0) chk("rd_addr", mem_address, q[0].addr);
         end
         if (mem_wr) begin
            wr_seen++;
            wr_addr = mem_address;
            wr_data = mem_data_in;
         end
         if (cpu_ack) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: got ack with empty scoreboard (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("ack_cycle", cyc, e.ack_cyc);
               chk("err", {31'd0, cpu_err}, {31'd0, e.err});
               chk("rdata", cpu_rdata, e.rdata);
               chk("rd_cycles", rd_seen, e.rd_n);
               chk("wr_cycles", wr_seen, e.wr_n);
               if (e.wr_n == 1) begin
                  chk("wr_addr", wr_addr, e.addr);
                  chk("wr_data", wr_data, e.wdata);
               end
            end
            rd_seen = 0;
            wr_seen = 0;
         end
      end
   end
   task automatic ref_reset();
      for (int i = 0; i < 32; i++) ref_mem[i] = img(i);
      ref_rdata = '0;
   endtask
   task automatic start(logic we, logic [31:0] addr, logic [31:0] wdata);
      exp_t e;
      int   t;
      bit   mis;
      t = 0;
      while (busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("idle_timeout", {31'd0, busy}, 32'd0);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      mis = addr[1:0] != 2'b00;
      if (!mis && we) ref_mem[widx(addr)] = wdata;
      if (!mis && !we) ref_rdata = ref_mem[widx(addr)];
      e.err     = mis;
      e.rdata   = ref_rdata;
      e.ack_cyc = cyc + (mis ? 1 : we ? 2 : WS + 2);
      e.rd_n    = (!mis && !we) ? WS : 0;
      e.wr_n    = (!mis && we) ? 1 : 0;
      e.addr    = addr;
      e.wdata   = wdata;
      q.push_back(e);
      @(negedge clk);
   endtask
   // Inputs are scrambled while the controller is busy; the latched copies must win.
   task automatic finish_txn();
      int t;
      t = 0;
      while (busy && t < 100) begin
         cpu_req   = 1'b1;
         cpu_we    = 1'($urandom);
         cpu_addr  = $urandom;
         cpu_wdata = $urandom;
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("busy_timeout", {31'd0, busy}, 32'd0);
      cpu_req = 1'b0;
   endtask
   task automatic issue(logic we, logic [31:0] addr, logic [31:0] wdata);
      start(we, addr, wdata);
      finish_txn();
   endtask
   initial begin
      rst = 1'b1;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      cpu_addr = '0;
      cpu_wdata = '0;
      ref_reset();
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ack", {31'd0, cpu_ack}, 32'd0);
      chk("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      chk("rst_addr", mem_address, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      issue(1'b0, 32'd2048, 32'd0);
      chk("plan_2048", cpu_rdata, 32'hC2002818);
      issue(1'b1, 32'd2076, 32'hDEADBEEF);
      issue(1'b0, 32'd2076, 32'd0);
      chk("plan_wr_rd", cpu_rdata, 32'hDEADBEEF);
      issue(1'b0, 32'd2050, 32'd0);
      chk("plan_mis_hold", cpu_rdata, 32'hDEADBEEF);
      issue(1'b0, 32'd2064, 32'd0);
      chk("plan_2064", cpu_rdata, 32'h81C3E810);
      start(1'b0, 32'd2068, 32'd0);
      cpu_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_ack", {31'd0, cpu_ack}, 32'd0);
      chk("midrst_rd", {31'd0, mem_rd}, 32'd0);
      rst = 1'b0;
      void'(q.pop_back());
      ref_reset();
      @(negedge clk);
      chk("midrst_idle", {31'd0, busy}, 32'd0);
      issue(1'b0, 32'd2068, 32'd0);
      chk("plan_2068", cpu_rdata, 32'h00000070);
      for (int i = 0; i < 3; i++) begin
         start(1'b0, 32'd2072, 32'd0);
         finish_txn();
         start(1'b0, 32'd2048, 32'd0);
         finish_txn();
      end
      chk("plan_b2b", cpu_rdata, 32'hC2002818);
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         a = 32'd2048 + 32'($urandom_range(0, 31) * 4);
         if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
         start(1'($urandom), a, $urandom);
         finish_txn();
      end
      for (int t = 0; t < 50 && q.size() > 0; t++) @(negedge clk);
      if (q.size() > 0) chk("drain", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
